regfile_wb_arbiter: RTL and testbench

Shares the register file's single write port between two write-back sources: src0 (ALU result) and src1 (memory load data). Each source uses a valid/ready handshake, and a registered write port drives the register file's we/waddr/wdata. A per-register pending-write scoreboard is set at issue and cleared at grant, so decode can stall on RAW hazards against both read ports.

---
 rtl/regfile_wb_arbiter_pkg.sv | 17 +
 rtl/regfile_wb_arbiter_scoreboard.sv | 83 ++++++++
 rtl/regfile_wb_arbiter.sv | 115 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the register-file write-back arbiter.
//   NREG/AW/DW : register file geometry (must match the register file)
//   CW         : width of each per-register pending-write counter
//   wb_src_e   : write-back source index (SRC_ALU=0, SRC_MEM=1)
package regfile_wb_arbiter_pkg;

  localparam int NREG = 16;
  localparam int AW   = 4;
  localparam int DW   = 16;
  localparam int CW   = 2;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } wb_src_e;

endpackage

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// Pending-write scoreboard: one saturating-free CW-bit counter per register.
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   iss_valid/iss_addr  : decode issues a writer of iss_addr
//   iss_ready           : counter for iss_addr has room (or is being retired now)
//   grant_valid/addr    : write-back granted this cycle, retires one pending write
//   chk_addr0/1         : read-port addresses to check for hazards
//   chk_busy0/1         : addressed counter is non-zero (pre-update value)
//   sb_err              : sticky, set when a grant retires against a zero counter
module wb_scoreboard
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int P_NREG = NREG,
  parameter int P_AW   = AW,
  parameter int P_CW   = CW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iss_valid,
  input  logic [P_AW-1:0] iss_addr,
  output logic            iss_ready,
  input  logic            grant_valid,
  input  logic [P_AW-1:0] grant_addr,
  input  logic [P_AW-1:0] chk_addr0,
  input  logic [P_AW-1:0] chk_addr1,
  output logic            chk_busy0,
  output logic            chk_busy1,
  output logic            sb_err
);

  logic [P_CW-1:0]   r_cnt [P_NREG];
  logic [P_CW-1:0]   w_cnt_next [P_NREG];
  logic [P_NREG-1:0] w_inc;
  logic [P_NREG-1:0] w_dec;
  logic [P_NREG-1:0] w_err;
  logic              w_grant_hits_iss;
  logic              w_iss_accept;
  logic              r_sb_err;

  // A full counter can still accept an issue when the same register is
  // being retired in this cycle: the two updates cancel.
  assign w_grant_hits_iss = grant_valid && (grant_addr == iss_addr);
  assign iss_ready        = (r_cnt[iss_addr] != '1) || w_grant_hits_iss;
  assign w_iss_accept     = iss_valid && iss_ready;

  // Hazard check deliberately uses the registered counters (no bypass).
  assign chk_busy0 = (r_cnt[chk_addr0] != '0);
  assign chk_busy1 = (r_cnt[chk_addr1] != '0);
  assign sb_err    = r_sb_err;

  generate
    for (genvar gi = 0; gi < P_NREG; gi++) begin : g_cnt
      assign w_inc[gi] = w_iss_accept && (iss_addr == P_AW'(gi));
      assign w_dec[gi] = grant_valid && (grant_addr == P_AW'(gi));
      // A retire matched by a same-cycle issue is covered by that issue.
      assign w_err[gi] = w_dec[gi] && !w_inc[gi] && (r_cnt[gi] == '0);

      always_comb begin
        w_cnt_next[gi] = r_cnt[gi];
        if (w_inc[gi] && !w_dec[gi]) begin
          w_cnt_next[gi] = r_cnt[gi] + 1'b1;
        end else if (w_dec[gi] && !w_inc[gi] && (r_cnt[gi] != '0)) begin
          w_cnt_next[gi] = r_cnt[gi] - 1'b1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < P_NREG; i++) begin
        r_cnt[i] <= '0;
      end
      r_sb_err <= 1'b0;
    end else begin
      for (int i = 0; i < P_NREG; i++) begin
        r_cnt[i] <= w_cnt_next[i];
      end
      r_sb_err <= r_sb_err || (|w_err);
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-source write-back arbiter for the register file's single write port.
// Ports:
//   clk, rst                  : clock, asynchronous active-low reset
//   s0_valid/addr/data/ready  : ALU write-back handshake
//   s1_valid/addr/data/ready  : load write-back handshake
//   iss_valid/addr/ready      : decode issue into the pending-write scoreboard
//   chk_addr0/1, chk_busy0/1  : RAW hazard check for the two read ports
//   rf_we/waddr/wdata         : registered register-file write port
//   sb_err                    : sticky scoreboard underflow error
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int P_NREG = NREG,
  parameter int P_AW   = AW,
  parameter int P_DW   = DW,
  parameter int P_CW   = CW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s0_valid,
  input  logic [P_AW-1:0] s0_addr,
  input  logic [P_DW-1:0] s0_data,
  output logic            s0_ready,
  input  logic            s1_valid,
  input  logic [P_AW-1:0] s1_addr,
  input  logic [P_DW-1:0] s1_data,
  output logic            s1_ready,
  input  logic            iss_valid,
  input  logic [P_AW-1:0] iss_addr,
  output logic            iss_ready,
  input  logic [P_AW-1:0] chk_addr0,
  input  logic [P_AW-1:0] chk_addr1,
  output logic            chk_busy0,
  output logic            chk_busy1,
  output logic            rf_we,
  output logic [P_AW-1:0] rf_waddr,
  output logic [P_DW-1:0] rf_wdata,
  output logic            sb_err
);

  wb_src_e         r_last_grant;
  logic            r_we;
  logic [P_AW-1:0] r_waddr;
  logic [P_DW-1:0] r_wdata;

  logic            w_gnt0;
  logic            w_gnt1;
  logic            w_gnt_valid;
  logic [P_AW-1:0] w_gnt_addr;
  logic [P_DW-1:0] w_gnt_data;

  // Round robin: on contention the source that did not win last time wins.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (s0_valid && s1_valid) begin
      if (r_last_grant == SRC_MEM) begin
        w_gnt0 = 1'b1;
      end else begin
        w_gnt1 = 1'b1;
      end
    end else begin
      w_gnt0 = s0_valid;
      w_gnt1 = s1_valid;
    end
  end

  assign w_gnt_valid = w_gnt0 || w_gnt1;
  assign w_gnt_addr  = w_gnt1 ? s1_addr : s0_addr;
  assign w_gnt_data  = w_gnt1 ? s1_data : s0_data;

  assign s0_ready = w_gnt0;
  assign s1_ready = w_gnt1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_grant <= SRC_MEM;
      r_we         <= 1'b0;
      r_waddr      <= '0;
      r_wdata      <= '0;
    end else begin
      r_we <= w_gnt_valid;
      // Address/data hold their last value when nothing is granted.
      if (w_gnt_valid) begin
        r_waddr      <= w_gnt_addr;
        r_wdata      <= w_gnt_data;
        r_last_grant <= w_gnt1 ? SRC_MEM : SRC_ALU;
      end
    end
  end

  assign rf_we    = r_we;
  assign rf_waddr = r_waddr;
  assign rf_wdata = r_wdata;

  wb_scoreboard #(
    .P_NREG (P_NREG),
    .P_AW   (P_AW),
    .P_CW   (P_CW)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .iss_valid   (iss_valid),
    .iss_addr    (iss_addr),
    .iss_ready   (iss_ready),
    .grant_valid (w_gnt_valid),
    .grant_addr  (w_gnt_addr),
    .chk_addr0   (chk_addr0),
    .chk_addr1   (chk_addr1),
    .chk_busy0   (chk_busy0),
    .chk_busy1   (chk_busy1),
    .sb_err      (sb_err)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios followed by
// randomized traffic, all compared against a behavioural model.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        s0_valid;
  logic [3:0]  s0_addr;
  logic [15:0] s0_data;
  logic        s0_ready;
  logic        s1_valid;
  logic [3:0]  s1_addr;
  logic [15:0] s1_data;
  logic        s1_ready;
  logic        iss_valid;
  logic [3:0]  iss_addr;
  logic        iss_ready;
  logic [3:0]  chk_addr0;
  logic [3:0]  chk_addr1;
  logic        chk_busy0;
  logic        chk_busy1;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        sb_err;

  regfile_wb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .s0_valid  (s0_valid),
    .s0_addr   (s0_addr),
    .s0_data   (s0_data),
    .s0_ready  (s0_ready),
    .s1_valid  (s1_valid),
    .s1_addr   (s1_addr),
    .s1_data   (s1_data),
    .s1_ready  (s1_ready),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .iss_ready (iss_ready),
    .chk_addr0 (chk_addr0),
    .chk_addr1 (chk_addr1),
    .chk_busy0 (chk_busy0),
    .chk_busy1 (chk_busy1),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .sb_err    (sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Behavioural model state (what the DUT should hold after the last edge)
  int m_cnt [16];
  bit m_we;
  int m_waddr;
  int m_wdata;
  bit m_err;
  int m_last;      // source that won the last grant (0 = ALU, 1 = load)
  bit p_g0;        // grants predicted in the most recent step
  bit p_g1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_cnt[i] = 0;
    m_we    = 0;
    m_waddr = 0;
    m_wdata = 0;
    m_err   = 0;
    m_last  = 1;
    p_g0    = 0;
    p_g1    = 0;
  endtask

  task automatic idle_inputs();
    s0_valid  = 0; s0_addr = 0; s0_data = 0;
    s1_valid  = 0; s1_addr = 0; s1_data = 0;
    iss_valid = 0; iss_addr = 0;
    chk_addr0 = 0; chk_addr1 = 0;
  endtask

  // One clock cycle: check every output at the falling edge against the model,
  // then advance the model at the rising edge. Entered/left at posedge+1.
  task automatic step(input string tag);
    bit g0, g1, gv, ird, acc;
    int ga, gd, ia;
    @(negedge clk);
    g0  = s0_valid && (!s1_valid || m_last == 1);
    g1  = s1_valid && (!s0_valid || m_last == 0);
    gv  = g0 || g1;
    ga  = g1 ? int'(s1_addr) : int'(s0_addr);
    gd  = g1 ? int'(s1_data) : int'(s0_data);
    ia  = int'(iss_addr);
    ird = (m_cnt[ia] != 3) || (gv && ga == ia);
    acc = iss_valid && ird;
    check({tag, ".s0_ready"},  s0_ready,  g0);
    check({tag, ".s1_ready"},  s1_ready,  g1);
    check({tag, ".iss_ready"}, iss_ready, ird);
    check({tag, ".chk_busy0"}, chk_busy0, m_cnt[chk_addr0] != 0);
    check({tag, ".chk_busy1"}, chk_busy1, m_cnt[chk_addr1] != 0);
    check({tag, ".rf_we"},     rf_we,     m_we);
    check({tag, ".rf_waddr"},  rf_waddr,  m_waddr);
    check({tag, ".rf_wdata"},  rf_wdata,  m_wdata);
    check({tag, ".sb_err"},    sb_err,    m_err);
    @(posedge clk);
    // An issue adds a pending write; a grant retires one. Retiring from
    // nothing flags the error and leaves the count at zero.
    if (acc) m_cnt[ia]++;
    if (gv) begin
      if (m_cnt[ga] == 0) m_err = 1;
      else m_cnt[ga]--;
      m_waddr = ga;
      m_wdata = gd;
      m_last  = g1 ? 1 : 0;
    end
    m_we = gv;
    p_g0 = g0;
    p_g1 = g1;
    #1;
  endtask

  // Assert reset between edges and confirm the outputs clear without a clock.
  task automatic async_reset(input string tag);
    #2;
    rst = 0;
    #1;
    check({tag, ".rst_we"},    rf_we,    0);
    check({tag, ".rst_waddr"}, rf_waddr, 0);
    check({tag, ".rst_wdata"}, rf_wdata, 0);
    check({tag, ".rst_err"},   sb_err,   0);
    idle_inputs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
  endtask

  int exp_seq [4] = '{4, 5, 4, 5};

  initial begin
    rst = 0;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    check("reset.rf_we",  rf_we,  0);
    check("reset.sb_err", sb_err, 0);
    rst = 1;
    @(posedge clk);
    #1;
    step("reset");

    // Single ALU write to r3
    s0_valid = 1; s0_addr = 3; s0_data = 16'h0001;
    step("t1.grant");
    s0_valid = 0;
    check("t1.rf_waddr", rf_waddr, 3);
    step("t1.write");
    step("t1.idle");

    // Contention: grants alternate starting with src0
    async_reset("t2");
    s0_valid = 1; s0_addr = 4; s0_data = 8;
    s1_valid = 1; s1_addr = 5; s1_data = 9;
    for (int k = 0; k < 4; k++) begin
      step("t2.rr");
      check("t2.seq", rf_waddr, exp_seq[k]);
    end
    idle_inputs();
    step("t2.drain");

    // Scoreboard saturation on r2, then a retire frees a slot
    async_reset("t3");
    chk_addr0 = 2;
    iss_valid = 1; iss_addr = 2;
    repeat (3) step("t3.issue");
    step("t3.full");
    check("t3.busy0", chk_busy0, 1);
    iss_valid = 0;
    s1_valid = 1; s1_addr = 2; s1_data = 16'hbeef;
    step("t3.retire");
    s1_valid = 0;
    step("t3.after");

    // Same-cycle issue and grant on r7 leave its count at 1
    chk_addr1 = 7;
    iss_valid = 1; iss_addr = 7;
    step("t4.issue");
    s0_valid = 1; s0_addr = 7; s0_data = 16'h0777;
    step("t4.both");
    idle_inputs();
    chk_addr1 = 7;
    step("t4.after");
    check("t4.busy1", chk_busy1, 1);

    // Retire against an empty counter sets the sticky error
    async_reset("t5");
    s0_valid = 1; s0_addr = 9; s0_data = 16'h0099;
    step("t5.grant");
    s0_valid = 0;
    check("t5.err", sb_err, 1);
    step("t5.hold0");
    step("t5.hold1");
    async_reset("t5");

    // Reset with a write pending on r6 drops it
    s1_valid = 1; s1_addr = 6; s1_data = 16'h0666;
    step("t6.grant");
    check("t6.we", rf_we, 1);
    async_reset("t6");
    step("t6.after0");
    step("t6.after1");

    // Randomized traffic on a small address range to hit saturation
    for (int c = 0; c < 400; c++) begin
      if (c == 200) async_reset("rnd");
      if (!s0_valid || p_g0) begin
        s0_valid = ($urandom_range(0, 2) != 0);
        s0_addr  = 4'($urandom_range(0, 3));
        s0_data  = 16'($urandom);
      end
      if (!s1_valid || p_g1) begin
        s1_valid = ($urandom_range(0, 2) != 0);
        s1_addr  = 4'($urandom_range(0, 3));
        s1_data  = 16'($urandom);
      end
      iss_valid = ($urandom_range(0, 1) != 0);
      iss_addr  = 4'($urandom_range(0, 3));
      chk_addr0 = 4'($urandom_range(0, 4));
      chk_addr1 = 4'($urandom_range(0, 4));
      step("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
